// File: rtl/dtmf_pkg.sv
// Shared definitions for the DTMF tone sequencer: state encoding,
// default burst/gap durations, keypad codes and tone bit indices.
package dtmf_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Default durations in 1 MHz clock cycles (100 ms each)
   localparam int DEF_TONE_CYCLES = 100000;
   localparam int DEF_GAP_CYCLES  = 100000;

   // Keypad codes: [3:2] = row index, [1:0] = column index
   localparam logic [3:0] KEY_1    = 4'b0000;
   localparam logic [3:0] KEY_2    = 4'b0001;
   localparam logic [3:0] KEY_3    = 4'b0010;
   localparam logic [3:0] KEY_A    = 4'b0011;
   localparam logic [3:0] KEY_4    = 4'b0100;
   localparam logic [3:0] KEY_5    = 4'b0101;
   localparam logic [3:0] KEY_6    = 4'b0110;
   localparam logic [3:0] KEY_B    = 4'b0111;
   localparam logic [3:0] KEY_7    = 4'b1000;
   localparam logic [3:0] KEY_8    = 4'b1001;
   localparam logic [3:0] KEY_9    = 4'b1010;
   localparam logic [3:0] KEY_C    = 4'b1011;
   localparam logic [3:0] KEY_STAR = 4'b1100;
   localparam logic [3:0] KEY_0    = 4'b1101;
   localparam logic [3:0] KEY_HASH = 4'b1110;
   localparam logic [3:0] KEY_D    = 4'b1111;

   // Bit positions of each tone within row_clks / col_clks
   localparam int ROW_697  = 0;
   localparam int ROW_770  = 1;
   localparam int ROW_852  = 2;
   localparam int ROW_941  = 3;
   localparam int COL_1209 = 0;
   localparam int COL_1336 = 1;
   localparam int COL_1477 = 2;
   localparam int COL_1633 = 3;

endpackage

// File: rtl/dtmf_tone_mux.sv
// Combinational row/column tone select and 2-bit sum for one key code.
// Kept separate so a receiver-side loopback checker can reuse it.
module dtmf_tone_mux (
   input  logic [3:0] row_clks,
   input  logic [3:0] col_clks,
   input  logic [3:0] key,
   output logic [1:0] level
);

   logic [3:0] row_hit;
   logic [3:0] col_hit;

   // One-hot gate each tone by the key's row and column index
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sel
         assign row_hit[gi] = row_clks[gi] & (key[3:2] == 2'(gi));
         assign col_hit[gi] = col_clks[gi] & (key[1:0] == 2'(gi));
      end
   endgenerate

   // Zero-extended sum: at most 1 + 1 = 2, so two bits never overflow
   assign level = {1'b0, |row_hit} + {1'b0, |col_hit};

endmodule

// File: rtl/dtmf_tone_sequencer.sv
// DTMF tone sequencer: accepts keypad codes through a one-deep buffer and
// emits, per key, a fixed tone burst (row + column square wave sum)
// followed by a fixed silent gap.
module dtmf_tone_sequencer
   import dtmf_pkg::*;
#(
   parameter int TONE_CYCLES = DEF_TONE_CYCLES,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int CNT_W       = 17
) (
   input  logic       inclk,
   input  logic       reset,
   input  logic [3:0] row_clks,
   input  logic [3:0] col_clks,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   input  logic       flush,
   output logic [1:0] tone_level,
   output logic       tone_active,
   output logic [3:0] key_out
);

   localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             buf_full_reg;
   logic [3:0]       buf_code_reg;
   logic [3:0]       key_out_reg;
   logic [1:0]       tone_level_reg;
   logic             tone_active_reg;
   logic             load;
   logic             accept;
   logic [1:0]       mux_level;

   // Ready only when the buffer is free and the block is out of reset
   assign key_ready = !buf_full_reg && !reset;
   // A key offered together with flush is dropped
   assign accept    = key_valid && key_ready && !flush;

   dtmf_tone_mux u_mux (
      .row_clks (row_clks),
      .col_clks (col_clks),
      .key      (key_out_reg),
      .level    (mux_level)
   );

   // Next-state, duration counter and buffer-load decision
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (buf_full_reg) begin
               load       = 1'b1;
               cnt_next   = '0;
               state_next = TONE;
            end
         end
         TONE: begin
            if (cnt_reg == TONE_LAST) begin
               cnt_next   = '0;
               state_next = GAP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         GAP: begin
            if (cnt_reg == GAP_LAST) begin
               cnt_next = '0;
               if (buf_full_reg) begin
                  // Chain straight into the next burst, skipping IDLE
                  load       = 1'b1;
                  state_next = TONE;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // State, counter, pending buffer and sounded key registers
   always_ff @(posedge inclk) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         buf_full_reg <= 1'b0;
         buf_code_reg <= '0;
         key_out_reg  <= '0;
      end else if (flush) begin
         // Abort: key_out deliberately keeps the last sounded code
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         buf_full_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (load) begin
            key_out_reg <= buf_code_reg;
         end
         // accept only happens with an empty buffer, load only with a full
         // one, so the two never collide on the same entry
         if (accept) begin
            buf_full_reg <= 1'b1;
            buf_code_reg <= key_code;
         end else if (load) begin
            buf_full_reg <= 1'b0;
         end
      end
   end

   // Registered tone outputs, silent outside the burst
   always_ff @(posedge inclk) begin
      if (reset || flush) begin
         tone_level_reg  <= 2'd0;
         tone_active_reg <= 1'b0;
      end else begin
         tone_level_reg  <= (state_reg == TONE) ? mux_level : 2'd0;
         tone_active_reg <= (state_reg == TONE);
      end
   end

   assign tone_level  = tone_level_reg;
   assign tone_active = tone_active_reg;
   assign key_out     = key_out_reg;

endmodule
